// File: rtl/acc_bin_reader.sv
// rtl/acc_bin_reader.sv - streams a snapshot of accumulator bins out as addressed beats
//
// Purpose: on start, freezes the accumulator vector, then sends each bin (or
// only the nonzero ones) as a valid/ready beat tagged with its bin index,
// sums what was sent, and signals pass end with done (plus an optional
// accumulator clear request).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bins_in           NUM_BINS packed bins, bin k at [k*BIN_W +: BIN_W]
//   start             begin a pass (ignored while busy)
//   skip_zero         latched with start; suppress zero-valued bins
//   clr_after         latched with start; pulse clear_req at pass end
//   out_valid/ready   beat handshake
//   out_addr/out_data bin index and value of the current beat
//   out_last          current beat is the final one of the pass
//   busy              pass in progress
//   done              one-cycle pass-end pulse
//   clear_req         one-cycle pulse with done when clr_after was latched
//   total             sum of beats sent in the last pass, updated at done
module acc_bin_reader #(
   parameter int NUM_BINS = 8,
   parameter int BIN_W    = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_BINS*BIN_W-1:0] bins_in,
   input  logic                      start,
   input  logic                      skip_zero,
   input  logic                      clr_after,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2:0]                out_addr,
   output logic [BIN_W-1:0]          out_data,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done,
   output logic                      clear_req,
   output logic [BIN_W+2:0]          total
);

   localparam int AW = 3;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

   state_t                    state_q, state_d;
   logic [NUM_BINS*BIN_W-1:0] snap_q, snap_d;
   logic                      skip_q, skip_d;
   logic                      clr_q, clr_d;
   logic [AW-1:0]             addr_q, addr_d;
   logic [BIN_W+2:0]          sum_q, sum_d;
   logic [BIN_W+2:0]          total_q, total_d;

   logic [NUM_BINS-1:0]       mask;
   logic                      mask_empty;
   logic [AW-1:0]             first_addr, next_addr, last_addr;

   // The snapshot is frozen for the whole pass, so the send mask can be
   // derived combinationally from it instead of being stored.
   always_comb begin
      mask = '0;
      for (int k = 0; k < NUM_BINS; k++) begin
         mask[k] = !skip_q || (snap_q[k*BIN_W +: BIN_W] != '0);
      end
      mask_empty = (mask == '0);
   end

   // Descending scan leaves the lowest qualifying index; ascending scan
   // leaves the highest set bit.
   always_comb begin
      first_addr = '0;
      next_addr  = '0;
      last_addr  = '0;
      for (int k = NUM_BINS - 1; k >= 0; k--) begin
         if (mask[k]) first_addr = AW'(k);
         if (mask[k] && (k > int'(addr_q))) next_addr = AW'(k);
      end
      for (int k = 0; k < NUM_BINS; k++) begin
         if (mask[k]) last_addr = AW'(k);
      end
   end

   assign out_valid = (state_q == SEND);
   assign out_addr  = addr_q;
   assign out_data  = snap_q[int'(addr_q)*BIN_W +: BIN_W];
   assign out_last  = out_valid && (addr_q == last_addr);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign clear_req = done && clr_q;
   assign total     = total_q;

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      skip_d  = skip_q;
      clr_d   = clr_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      total_d = total_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               snap_d  = bins_in;
               skip_d  = skip_zero;
               clr_d   = clr_after;
               sum_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (mask_empty) begin
               total_d = '0;
               state_d = DONE;
            end else begin
               addr_d  = first_addr;
               state_d = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               sum_d = sum_q + {3'b000, out_data};
               if (out_last) begin
                  // total must already hold the final sum during the done cycle
                  total_d = sum_d;
                  state_d = DONE;
               end else begin
                  addr_d = next_addr;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         snap_q  <= '0;
         skip_q  <= 1'b0;
         clr_q   <= 1'b0;
         addr_q  <= '0;
         sum_q   <= '0;
         total_q <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         skip_q  <= skip_d;
         clr_q   <= clr_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         total_q <= total_d;
      end
   end

endmodule

// File: tb/tb_acc_bin_reader.sv
// tb/tb_acc_bin_reader.sv - self-checking bench for acc_bin_reader
module tb_acc_bin_reader;

   localparam int NB = 8;
   localparam int BW = 20;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NB*BW-1:0] bins_in = '0;
   logic             start = 1'b0;
   logic             skip_zero = 1'b0;
   logic             clr_after = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [2:0]       out_addr;
   logic [BW-1:0]    out_data;
   logic             out_last;
   logic             busy;
   logic             done;
   logic             clear_req;
   logic [BW+2:0]    total;

   acc_bin_reader #(.NUM_BINS(NB), .BIN_W(BW)) dut (
      .clk(clk), .rst(rst), .bins_in(bins_in), .start(start),
      .skip_zero(skip_zero), .clr_after(clr_after),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
      .clear_req(clear_req), .total(total)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: a pass is a queue of (addr,data) beats built from the
   // captured bins; the head is offered after one setup cycle and popped on
   // each accepted handshake.
   bit             m_busy = 0, m_done_now = 0, m_clr_now = 0, m_clr_l = 0, m_fresh = 1;
   int             m_wait = 0;
   int             qa[$];
   logic [BW-1:0]  qd[$];
   logic [BW+2:0]  m_total = '0, m_pass_sum = '0;

   int             log_a[$];
   logic [BW-1:0]  log_d[$];
   int             done_cnt = 0, clr_cnt = 0;

   initial forever begin
      @(posedge clk);
      if (!rst && out_valid && out_ready) begin
         log_a.push_back(int'(out_addr));
         log_d.push_back(out_data);
      end
      if (!rst && done) done_cnt++;
      if (!rst && clear_req) clr_cnt++;
      if (rst) begin
         m_busy = 0; m_wait = 0; m_done_now = 0; m_clr_now = 0;
         m_total = '0; m_fresh = 1;
         qa.delete(); qd.delete();
      end else if (m_done_now) begin
         m_done_now = 0; m_clr_now = 0; m_busy = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_pass_sum = '0;
            for (int k = 0; k < NB; k++) begin
               logic [BW-1:0] v;
               v = bins_in[k*BW +: BW];
               if (!skip_zero || v != 0) begin
                  qa.push_back(k);
                  qd.push_back(v);
                  m_pass_sum = m_pass_sum + {3'b000, v};
               end
            end
            m_clr_l = clr_after;
            m_busy = 1; m_wait = 1; m_fresh = 0;
         end
      end else if (m_wait > 0) begin
         m_wait = 0;
         if (qa.size() == 0) begin
            m_done_now = 1; m_total = m_pass_sum; m_clr_now = m_clr_l;
         end
      end else if (out_ready) begin
         void'(qa.pop_front());
         void'(qd.pop_front());
         if (qa.size() == 0) begin
            m_done_now = 1; m_total = m_pass_sum; m_clr_now = m_clr_l;
         end
      end
   end

   // Per-cycle comparison against the model, after outputs settle.
   initial forever begin
      bit ev;
      @(posedge clk);
      #1;
      ev = m_busy && (m_wait == 0) && !m_done_now && (qa.size() > 0);
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done_now));
      chk("clear_req", 64'(clear_req), 64'(m_clr_now));
      chk("total", 64'(total), 64'(m_total));
      chk("out_valid", 64'(out_valid), 64'(ev));
      if (ev) begin
         chk("out_addr", 64'(out_addr), 64'(qa[0]));
         chk("out_data", 64'(out_data), 64'(qd[0]));
         chk("out_last", 64'(out_last), 64'(qa.size() == 1));
      end else begin
         chk("out_last_idle", 64'(out_last), 64'd0);
      end
      if (m_fresh) begin
         chk("addr_after_rst", 64'(out_addr), 64'd0);
         chk("data_after_rst", 64'(out_data), 64'd0);
      end
   end

   // out_ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
   int rdy_mode = 0;
   initial begin
      int p;
      p = 0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            1:       out_ready = ((p % 4) == 0) || ((p % 4) == 3);
            2:       out_ready = 1'($urandom);
            default: out_ready = 1'b1;
         endcase
         p++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [NB*BW-1:0] rand_bins();
      logic [NB*BW-1:0] b;
      for (int k = 0; k < NB; k++) begin
         case ($urandom_range(0, 3))
            0:       b[k*BW +: BW] = '0;
            1:       b[k*BW +: BW] = 20'hFFFFF;
            default: b[k*BW +: BW] = 20'($urandom);
         endcase
      end
      return b;
   endfunction

   task automatic do_start(input logic [NB*BW-1:0] b, input logic s, input logic c);
      bins_in = b; skip_zero = s; clr_after = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      skip_zero = 1'($urandom);
      clr_after = 1'($urandom);
   endtask

   task automatic wait_idle(input int bound, input string name);
      int i;
      for (i = 0; i < bound; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk({name, "_timeout"}, 64'(i < bound), 64'd1);
   endtask

   task automatic check_seq35(input string name);
      chk({name, "_beats"}, 64'(log_a.size()), 64'd8);
      for (int i = 0; i < 8 && i < log_a.size(); i++) begin
         chk({name, "_addr"}, 64'(log_a[i]), 64'(i));
         chk({name, "_data"}, 64'(log_d[i]), 64'(i + 1));
      end
      chk({name, "_total"}, 64'(total), 64'd36);
      chk({name, "_model_total"}, 64'(m_total), 64'd36);
   endtask

   initial begin
      logic [NB*BW-1:0] b35, b36, bff;
      int d0, c0;
      for (int k = 0; k < NB; k++) b35[k*BW +: BW] = 20'(k + 1);
      b36 = '0;
      b36[1*BW +: BW] = 20'd5;
      b36[4*BW +: BW] = 20'hFFFFF;
      b36[7*BW +: BW] = 20'd3;
      bff = '1;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_total", 64'(total), 64'd0);

      // Plain pass, always ready
      rdy_mode = 0; log_a.delete(); log_d.delete(); d0 = done_cnt; c0 = clr_cnt;
      do_start(b35, 1'b0, 1'b0);
      @(negedge clk);
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_addr", 64'(out_addr), 64'd0);
      wait_idle(40, "p35");
      check_seq35("p35");
      chk("p35_done_cnt", 64'(done_cnt - d0), 64'd1);
      chk("p35_clr_cnt", 64'(clr_cnt - c0), 64'd0);

      // Sparse bins with skip_zero and clear request
      log_a.delete(); log_d.delete(); c0 = clr_cnt;
      do_start(b36, 1'b1, 1'b1);
      wait_idle(40, "p36");
      chk("p36_beats", 64'(log_a.size()), 64'd3);
      if (log_a.size() == 3) begin
         chk("p36_a0", 64'(log_a[0]), 64'd1);
         chk("p36_a1", 64'(log_a[1]), 64'd4);
         chk("p36_a2", 64'(log_a[2]), 64'd7);
      end
      chk("p36_total", 64'(total), 64'h100007);
      chk("p36_clr_cnt", 64'(clr_cnt - c0), 64'd1);

      // Empty mask
      log_a.delete(); log_d.delete();
      do_start('0, 1'b1, 1'b0);
      @(negedge clk);
      chk("p37_done", 64'(done), 64'd1);
      chk("p37_valid", 64'(out_valid), 64'd0);
      chk("p37_total", 64'(total), 64'd0);
      wait_idle(10, "p37");
      chk("p37_beats", 64'(log_a.size()), 64'd0);

      // Stalled handshake
      rdy_mode = 1; log_a.delete(); log_d.delete();
      do_start(b35, 1'b0, 1'b0);
      wait_idle(80, "p38");
      check_seq35("p38");

      // Saturated bins, restart during SEND, bins_in changing mid-pass
      rdy_mode = 2; log_a.delete(); log_d.delete(); d0 = done_cnt;
      do_start(bff, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      start = 1'b1; bins_in = rand_bins();
      @(negedge clk);
      start = 1'b0; bins_in = '0;
      wait_idle(200, "p39");
      @(negedge clk);
      chk("p39_idle", 64'(busy), 64'd0);
      chk("p39_total", 64'(total), 64'h7FFFF8);
      chk("p39_beats", 64'(log_a.size()), 64'd8);
      for (int i = 0; i < log_d.size(); i++) chk("p39_data", 64'(log_d[i]), 64'hFFFFF);
      chk("p39_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Reset mid-pass
      rdy_mode = 0; log_a.delete(); log_d.delete(); d0 = done_cnt; c0 = clr_cnt;
      do_start(b35, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("r40_valid", 64'(out_valid), 64'd0);
      chk("r40_busy", 64'(busy), 64'd0);
      chk("r40_addr", 64'(out_addr), 64'd0);
      chk("r40_data", 64'(out_data), 64'd0);
      chk("r40_last", 64'(out_last), 64'd0);
      chk("r40_total", 64'(total), 64'd0);
      repeat (3) @(negedge clk);
      chk("r40_no_done", 64'(done_cnt - d0), 64'd0);
      chk("r40_no_clr", 64'(clr_cnt - c0), 64'd0);
      log_a.delete(); log_d.delete();
      do_start(b35, 1'b0, 1'b0);
      wait_idle(40, "r40_pass");
      check_seq35("r40_pass");

      // Randomized passes, with held starts and occasional resets
      for (int it = 0; it < 60; it++) begin
         int hold;
         rdy_mode = $urandom_range(0, 2);
         bins_in = rand_bins();
         skip_zero = 1'($urandom);
         clr_after = 1'($urandom);
         start = 1'b1;
         hold = $urandom_range(1, 14);
         repeat (hold) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bins_in = rand_bins();
         end
         start = 1'b0;
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         wait_idle(300, "rand");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
